mii_tx_framer: RTL
==================

Name: mii_tx_framer

Overview:
- MII transmit framer for one 10/100 port; runs in the phy_tx_clk domain.
- Consumes payload bytes (destination MAC through the last data byte) from the bridge-side FIFO through a valid/ready handshake.
- Emits one MII nibble per clock: preamble, SFD, payload, zero-pad to the minimum frame size, FCS and inter-frame gap.
- It is the transmit counterpart of the MAC receive path. It drives phy_tx_en, phy_txd and phy_tx_err.

Parameters:
- IFG_NIBBLES, 24, idle nibbles enforced after every frame (24 nibbles = 96 bit times).
- MIN_PAYLOAD, 60, minimum bytes before FCS; shorter frames are zero-padded.
- PAD_EN, 1, 1 enables padding; 0 sends the payload as-is.

Ports:
- clk  in  1  transmit clock (phy_tx_clk); all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  in_data is the final payload byte of the frame.
- in_ready  out  1  framer accepts in_data this cycle.
- phy_tx_en  out  1  MII transmit enable.
- phy_txd  out  4  MII transmit nibble.
- phy_tx_err  out  1  MII transmit error.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse when the source starves mid-frame.

Behaviour:
- Reset values: phy_tx_en=0, phy_txd=0, phy_tx_err=0, in_ready=0, busy=0, underrun=0, state=IDLE, crc=FFFFFFFF.
- Outputs are registered.
- A byte transfers when in_valid && in_ready.
- Nibble order is low nibble first.
- State sequence: IDLE -> PRE -> SFD -> DLO/DHI -> PAD -> FCS -> IFG -> IDLE.
- IDLE: when in_valid=1 at an edge, go to PRE; phy_tx_en rises the following cycle.
  - A frame starts only at this edge; in_ready stays 0 in IDLE.
- PRE: 15 nibbles of 0x5.
- SFD: one nibble 0xD.
  - in_ready=1 during this cycle, to capture the first byte.
  - The crc register is re-initialised to FFFFFFFF.
- DLO: output byte[3:0].
- DHI: output byte[7:4].
  - in_ready=1 in this cycle unless the current byte carried in_last.
  - The next byte is captured here, so DLO follows DHI back-to-back.
- CRC: IEEE 802.3, reflected polynomial EDB88320, updated per byte as the byte is captured.
- Byte counter: saturates at MIN_PAYLOAD.
- After the DHI of the last byte:
  - if PAD_EN=1 and count < MIN_PAYLOAD, go to PAD;
  - otherwise go to FCS.
- PAD: emit 0x0 nibbles, two per byte. Each pad byte (00) enters the CRC and the byte count. Leave PAD when count reaches MIN_PAYLOAD.
- FCS: transmit ~crc, 8 nibbles, bits [3:0] first, then [7:4] and so on up to [31:28].
- IFG: phy_tx_en=0 for IFG_NIBBLES cycles, then IDLE.
  - in_valid is ignored during IFG.
  - An IFG count of 0 still spends one cycle in IFG.
- Underrun: in_ready=1 with in_valid=0 in SFD or DHI. Next cycle:
  - phy_tx_en=1, phy_tx_err=1, phy_txd=0 for exactly one nibble;
  - underrun pulses for one cycle;
  - CRC and pad are skipped; go to IFG.
  - Remaining bytes of that frame are not dropped by the framer; upstream flushes.
- phy_tx_err is 0 at all other times.
- phy_txd=0 whenever phy_tx_en=0.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). No FCS and no IFG are emitted; the next frame may start right after reset release.
- in_last on the first byte is legal: a 1-byte payload, padded to MIN_PAYLOAD when PAD_EN=1.
- Payload length has no upper limit; the framer does not truncate.

Test Plan:
- Reset, then idle with in_valid=0 -> phy_tx_en=0, txd=0, busy=0 for 100 cycles; async assert mid-cycle clears outputs before the next edge.
- PAD_EN=0, payload ASCII "123456789" (31..39, last on 39) -> after valid, exactly:
  - 15x 5, then D;
  - 18 data nibbles 1,3,2,3,...,9,3;
  - FCS nibbles 6,2,9,3,4,F,B,C (CRC CBF43926);
  - tx_en high for 34+8... exactly 42 cycles, then 24 cycles low.
- PAD_EN=1, 14-byte payload -> 92 pad nibbles of 0; 8 FCS nibbles equal the CRC of the 60-byte zero-extended frame computed by the bench model; tx_en high 16+120+8=144 cycles.
- Two back-to-back frames with in_valid held high -> second preamble starts exactly IFG_NIBBLES+1 cycles after the first frame's last FCS nibble; in_ready=0 throughout IFG.
- Drop in_valid at the 5th byte request -> one nibble with tx_en=1, tx_err=1, txd=0; underrun pulse of 1 cycle; then 24 idle cycles; next frame is correct.
- 64-byte payload with PAD_EN=1 -> no PAD state; CRC matches the model; in_ready asserted exactly 64 times.

Source files
------------

// File: rtl/mii_tx_framer.sv
// MII transmit framer: turns a byte stream into preamble, SFD, payload,
// optional zero-pad, FCS and inter-frame gap, one nibble per phy_tx_clk.
module mii_tx_framer #(
   parameter int IFG_NIBBLES = 24,
   parameter int MIN_PAYLOAD = 60,
   parameter bit PAD_EN      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       phy_tx_en,
   output logic [3:0] phy_txd,
   output logic       phy_tx_err,
   output logic       busy,
   output logic       underrun
);

   localparam int              CW       = (MIN_PAYLOAD < 2) ? 1 : $clog2(MIN_PAYLOAD + 1);
   localparam logic [CW-1:0]   MIN_CNT  = CW'(MIN_PAYLOAD);
   // IFG of 0 or 1 both leave after a single cycle
   localparam logic [15:0]     IFG_LAST = (IFG_NIBBLES > 1) ? 16'(IFG_NIBBLES - 1) : 16'd0;

   typedef enum logic [3:0] {
      IDLE, PRE, SFD, DLO, DHI, PAD, FCS, UNDR, IFG
   } state_t;

   state_t        state, state_n;
   logic [15:0]   cnt, cnt_n;
   logic [CW-1:0] count, count_n;
   logic [31:0]   crc, crc_n;
   logic [7:0]    cur, cur_n;
   logic          cur_last, cur_last_n;
   logic          en_n, err_n, rdy_n, und_n;
   logic [3:0]    txd_n;

   // IEEE 802.3 reflected CRC-32, one byte LSB first
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int unsigned i = 0; i < 8; i++) begin
         r = (r >> 1) ^ ((r[0] ^ b[i[2:0]]) ? 32'hEDB88320 : 32'h0000_0000);
      end
      return r;
   endfunction

   // Next state plus the output values for the cycle the next state occupies
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      count_n    = count;
      crc_n      = crc;
      cur_n      = cur;
      cur_last_n = cur_last;
      en_n       = 1'b0;
      txd_n      = 4'h0;
      err_n      = 1'b0;
      rdy_n      = 1'b0;
      und_n      = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = PRE;
               cnt_n   = '0;
               en_n    = 1'b1;
               txd_n   = 4'h5;
            end
         end
         PRE: begin
            en_n = 1'b1;
            if (cnt == 16'd14) begin
               state_n = SFD;
               txd_n   = 4'hD;
               rdy_n   = 1'b1;
               crc_n   = '1;
               count_n = '0;
            end else begin
               cnt_n = cnt + 16'd1;
               txd_n = 4'h5;
            end
         end
         SFD, DHI: begin
            en_n = 1'b1;
            if (in_ready && in_valid) begin
               state_n    = DLO;
               cur_n      = in_data;
               cur_last_n = in_last;
               crc_n      = crc_byte(crc, in_data);
               count_n    = (count == MIN_CNT) ? count : count + CW'(1);
               txd_n      = in_data[3:0];
            end else if (in_ready) begin
               state_n = UNDR;
               err_n   = 1'b1;
               und_n   = 1'b1;
            end else if (PAD_EN && count < MIN_CNT) begin
               state_n = PAD;
               cnt_n   = '0;
               crc_n   = crc_byte(crc, 8'h00);
               count_n = count + CW'(1);
            end else begin
               // FCS nibbles are taken from the bottom of the crc register as it shifts
               state_n = FCS;
               cnt_n   = '0;
               txd_n   = ~crc[3:0];
               crc_n   = crc >> 4;
            end
         end
         DLO: begin
            state_n = DHI;
            en_n    = 1'b1;
            txd_n   = cur[7:4];
            rdy_n   = ~cur_last;
         end
         PAD: begin
            en_n = 1'b1;
            if (!cnt[0]) begin
               cnt_n = 16'd1;
            end else if (count >= MIN_CNT) begin
               state_n = FCS;
               cnt_n   = '0;
               txd_n   = ~crc[3:0];
               crc_n   = crc >> 4;
            end else begin
               cnt_n   = '0;
               crc_n   = crc_byte(crc, 8'h00);
               count_n = count + CW'(1);
            end
         end
         FCS: begin
            if (cnt == 16'd7) begin
               state_n = IFG;
               cnt_n   = '0;
            end else begin
               en_n  = 1'b1;
               txd_n = ~crc[3:0];
               crc_n = crc >> 4;
               cnt_n = cnt + 16'd1;
            end
         end
         UNDR: begin
            state_n = IFG;
            cnt_n   = '0;
         end
         IFG: begin
            if (cnt == IFG_LAST) state_n = IDLE;
            else                 cnt_n   = cnt + 16'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   // State, datapath and registered MII outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         count      <= '0;
         crc        <= '1;
         cur        <= '0;
         cur_last   <= 1'b0;
         phy_tx_en  <= 1'b0;
         phy_txd    <= '0;
         phy_tx_err <= 1'b0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         count      <= count_n;
         crc        <= crc_n;
         cur        <= cur_n;
         cur_last   <= cur_last_n;
         phy_tx_en  <= en_n;
         phy_txd    <= txd_n;
         phy_tx_err <= err_n;
         in_ready   <= rdy_n;
         busy       <= (state_n != IDLE);
         underrun   <= und_n;
      end
   end

endmodule
